// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Port identifiers used for grant and last-grant tracking
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Byte-lane write enables for a data-port request; reads never write
    function automatic logic [3:0] lane_we(input logic is_write, input logic [3:0] mask);
        return is_write ? mask : 4'b0000;
    endfunction

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational winner select between instruction and data requesters.
// Tie policy depends on BRAM_ARB_RR_EN: round-robin when defined,
// fixed data-port priority otherwise.
module bram_arb_pick (
    input  logic i_stb,
    input  logic d_stb,
`ifdef BRAM_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic req,
    output logic grant
);
    import bram_arb_pkg::*;

    // Pick the winner; a lone requester always wins
    always_comb begin
        req   = i_stb | d_stb;
        grant = PORT_D;
        if (i_stb && !d_stb) begin
            grant = PORT_I;
        end else if (i_stb && d_stb) begin
`ifdef BRAM_ARB_RR_EN
            // Tie goes to whichever port was not served most recently
            grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
`else
            grant = PORT_D;
`endif
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one 32-bit, four-lane block RAM between the instruction-fetch and
// data ports. Each access takes IDLE -> ACCESS -> DONE, so latency is two
// cycles and peak throughput one access per three cycles.
// Optional feature macro: BRAM_ARB_RR_EN (round-robin tie-break).
module bram_arbiter #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_stb,
    input  logic [31:0]   i_addr,
    output logic          i_ack,
    output logic [31:0]   i_dtr,
    input  logic          d_stb,
    input  logic          d_rw,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_dtw,
    input  logic [3:0]    d_mask,
    output logic          d_ack,
    output logic [31:0]   d_dtr,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);
    import bram_arb_pkg::*;

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [3:0]    we_q;
    logic [31:0]   din_q;
    logic          grant_q;
    logic          req;
    logic          grant;

    // Upper address bits alias onto the BRAM and byte offsets are ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

`ifdef BRAM_ARB_RR_EN
    logic last_q;

    // Remember the most recent grant for round-robin tie-breaking
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_D;
        end else if (state_q == IDLE && req) begin
            last_q <= grant;
        end
    end
`endif

    bram_arb_pick u_pick (
        .i_stb      (i_stb),
        .d_stb      (d_stb),
`ifdef BRAM_ARB_RR_EN
        .last_grant (last_q),
`endif
        .req        (req),
        .grant      (grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; strobes only matter in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's address, lane enables and write data at grant time
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 4'b0000;
            din_q   <= 32'h0;
            grant_q <= PORT_D;
        end else if (state_q == IDLE && req) begin
            grant_q <= grant;
            if (grant == PORT_D) begin
                addr_q <= d_addr[AW+1:2];
                we_q   <= lane_we(d_rw, d_mask);
                din_q  <= d_dtw;
            end else begin
                addr_q <= i_addr[AW+1:2];
                we_q   <= 4'b0000;
                din_q  <= 32'h0;
            end
        end
    end

    // Outputs decoded from state; read data is gated to zero outside the ack
    always_comb begin
        mem_en   = (state_q == ACCESS);
        mem_we   = mem_en ? we_q : 4'b0000;
        mem_addr = addr_q;
        mem_din  = din_q;
        i_ack    = (state_q == DONE) && (grant_q == PORT_I);
        d_ack    = (state_q == DONE) && (grant_q == PORT_D);
        i_dtr    = i_ack ? mem_dout : 32'h0;
        d_dtr    = d_ack ? mem_dout : 32'h0;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural four-lane BRAM.
module tb_bram_arbiter;

    logic        clk;
    logic        reset;
    logic        i_stb;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_dtr;
    logic        d_stb;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_dtw;
    logic [3:0]  d_mask;
    logic        d_ack;
    logic [31:0] d_dtr;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Backdoor preload port into the BRAM model
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:4095];

    bram_arbiter #(.AW(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_stb    (i_stb),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_dtr    (i_dtr),
        .d_stb    (d_stb),
        .d_rw     (d_rw),
        .d_addr   (d_addr),
        .d_dtw    (d_dtw),
        .d_mask   (d_mask),
        .d_ack    (d_ack),
        .d_dtr    (d_dtr),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM with per-lane write enables
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        tick;
        pl_en   = 1'b0;
    endtask

    // One complete transaction starting in an IDLE cycle; ends in the next IDLE cycle
    task automatic xact(input string tag, input logic is_d, input logic rw,
                        input logic [31:0] addr, input logic [31:0] dtw, input logic [3:0] mask,
                        input logic [31:0] exp_maddr, input logic [3:0] exp_we,
                        input logic chk_data, input logic [31:0] exp_data);
        if (is_d) begin
            d_stb = 1'b1; d_rw = rw; d_addr = addr; d_dtw = dtw; d_mask = mask;
        end else begin
            i_stb = 1'b1; i_addr = addr;
        end
        tick;
        check({tag, ".access_en"},   {31'b0, mem_en}, 32'd1);
        check({tag, ".access_addr"}, {20'b0, mem_addr}, exp_maddr);
        check({tag, ".access_we"},   {28'b0, mem_we}, {28'b0, exp_we});
        check({tag, ".access_acks"}, {30'b0, i_ack, d_ack}, 32'd0);
        tick;
        check({tag, ".done_acks"}, {30'b0, i_ack, d_ack}, is_d ? 32'd1 : 32'd2);
        check({tag, ".done_en_we"}, {27'b0, mem_en, mem_we}, 32'd0);
        if (chk_data) check({tag, ".done_data"}, is_d ? d_dtr : i_dtr, exp_data);
        i_stb = 1'b0;
        d_stb = 1'b0;
        tick;
        check({tag, ".idle_acks"}, {30'b0, i_ack, d_ack}, 32'd0);
        check({tag, ".idle_dtr"},  i_dtr | d_dtr, 32'd0);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        i_stb = 1'b0; i_addr = '0;
        d_stb = 1'b0; d_rw = 1'b0; d_addr = '0; d_dtw = '0; d_mask = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(12'd5, 32'hDEADBEEF);
        preload(12'd8, 32'hFFFFFFFF);
        preload(12'd0, 32'hCAFEF00D);
        tick;

        // Reset state
        check("rst.acks",     {30'b0, i_ack, d_ack}, 32'd0);
        check("rst.en_we",    {27'b0, mem_en, mem_we}, 32'd0);
        check("rst.addr",     {20'b0, mem_addr}, 32'd0);
        check("rst.din",      mem_din, 32'd0);
        check("rst.dtr",      i_dtr | d_dtr, 32'd0);

        reset = 1'b0;
        tick;

        // Instruction fetch of word 5
        xact("ifetch", 1'b0, 1'b0, 32'h14, 32'h0, 4'h0, 32'd5, 4'h0, 1'b1, 32'hDEADBEEF);
        // Masked data write then read-back
        xact("dwrite", 1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101, 32'd8, 4'b0101, 1'b0, 32'h0);
        xact("dread",  1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'd8, 4'h0, 1'b1, 32'hFF22FF44);
        // High address bits alias onto word 0
        xact("alias",  1'b0, 1'b0, 32'h0000_4003, 32'h0, 4'h0, 32'd0, 4'h0, 1'b1, 32'hCAFEF00D);

        // Both strobes held continuously from reset
        i_stb = 1'b1; i_addr = 32'h14;
        d_stb = 1'b1; d_rw = 1'b0; d_addr = 32'h20;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check($sformatf("tie%0d.access_acks", k), {30'b0, i_ack, d_ack}, 32'd0);
            tick;
`ifdef BRAM_ARB_RR_EN
            check($sformatf("tie%0d.acks", k), {30'b0, i_ack, d_ack}, (k % 2 == 0) ? 32'd2 : 32'd1);
`else
            check($sformatf("tie%0d.acks", k), {30'b0, i_ack, d_ack}, 32'd1);
`endif
            tick;
            check($sformatf("tie%0d.idle_acks", k), {30'b0, i_ack, d_ack}, 32'd0);
        end
        d_stb = 1'b0;
        tick;
        tick;
        check("tie.d_dropped", {30'b0, i_ack, d_ack}, 32'd2);
        i_stb = 1'b0;
        tick;

        // Reset during ACCESS drops the read; a reissue completes normally
        i_stb = 1'b1; i_addr = 32'h14;
        tick;
        check("rsta.en", {31'b0, mem_en}, 32'd1);
        reset = 1'b1;
        tick;
        check("rsta.acks",  {30'b0, i_ack, d_ack}, 32'd0);
        check("rsta.en_we", {27'b0, mem_en, mem_we}, 32'd0);
        check("rsta.addr",  {20'b0, mem_addr}, 32'd0);
        check("rsta.din",   mem_din, 32'd0);
        check("rsta.dtr",   i_dtr | d_dtr, 32'd0);
        reset = 1'b0;
        xact("reissue", 1'b0, 1'b0, 32'h14, 32'h0, 4'h0, 32'd5, 4'h0, 1'b1, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
